// File: rtl/eth_pkg.sv
// Shared types and widths for the Ethernet frame buffer: writer state
// encodings and the bank address / frame length widths.
package eth_pkg;

    localparam int FRAME_AW    = 10;
    localparam int FRAME_LEN_W = 11;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_FILL  = 2'd1,
        W_CLOSE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/eth_frame_dpram.sv
// Simple dual-port RAM, one write port and one registered read port on a
// single clock; sized for two ping-pong frame banks.
module eth_frame_dpram #(
    parameter int AW = 11,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: the array itself has no reset so it maps onto block RAM; only the
    // read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eth_frame_buf.sv
// Ping-pong 2x1024x32 sample buffer between acquisition and the UDP sender:
// msync-delimited frames fill one bank while the sender drains the other.
module eth_frame_buf
    import eth_pkg::*;
#(
    parameter int FRAME_WORDS = 1024,
    parameter int SEQ_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_msync_n,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_wr_vld,
    input  logic [FRAME_AW-1:0]    i_rd_addr,
    output logic [31:0]            o_rd_data,
    output logic                   o_frame_rdy,
    output logic [FRAME_LEN_W-1:0] o_frame_len,
    output logic [SEQ_W-1:0]       o_frame_seq,
    input  logic                   i_frame_ack,
    output logic [SEQ_W-1:0]       o_ovf_cnt
);

    localparam logic [FRAME_LEN_W-1:0] LAST_PTR = FRAME_LEN_W'(FRAME_WORDS - 1);
    localparam logic [FRAME_LEN_W-1:0] FULL_LEN = FRAME_LEN_W'(FRAME_WORDS);

    logic                   msync_ff1, msync_ff2, msync_ff3;
    logic                   sync_fall;
    wr_state_t              state, state_d;
    logic [FRAME_LEN_W-1:0] wr_ptr, wr_ptr_d;
    logic [FRAME_LEN_W-1:0] close_len, close_len_d;
    logic                   ram_we;
    logic                   wr_bank, rd_bank;
    logic                   rd_free;

    // Two flops to resolve metastability, a third to find the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msync_ff1 <= 1'b1;
            msync_ff2 <= 1'b1;
            msync_ff3 <= 1'b1;
        end else begin
            msync_ff1 <= i_msync_n;
            msync_ff2 <= msync_ff1;
            msync_ff3 <= msync_ff2;
        end
    end

    assign sync_fall = msync_ff3 & ~msync_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= W_IDLE;
            wr_ptr    <= '0;
            close_len <= '0;
        end else begin
            // NOTE: state registers take non-blocking assignments so every
            // flop samples the pre-edge values of its neighbours.
            state     <= state_d;
            wr_ptr    <= wr_ptr_d;
            close_len <= close_len_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        wr_ptr_d    = wr_ptr;
        close_len_d = close_len;
        ram_we      = 1'b0;
        case (state)
            W_IDLE: begin
                wr_ptr_d = '0;
                if (sync_fall) begin
                    state_d = W_FILL;
                end
            end
            W_FILL: begin
                if (sync_fall) begin
                    // An early msync closes a partial frame; an empty one just restarts.
                    if (wr_ptr != '0) begin
                        close_len_d = wr_ptr;
                        state_d     = W_CLOSE;
                    end else begin
                        wr_ptr_d = '0;
                    end
                end else if (i_wr_vld) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr + FRAME_LEN_W'(1);
                    if (wr_ptr == LAST_PTR) begin
                        close_len_d = FULL_LEN;
                        state_d     = W_CLOSE;
                    end
                end
            end
            W_CLOSE: begin
                wr_ptr_d = '0;
                state_d  = W_IDLE;
            end
            default: begin
                wr_ptr_d = '0;
                state_d  = W_IDLE;
            end
        endcase
    end

    // An ack landing in the close cycle frees the read bank for the new frame.
    assign rd_free = !o_frame_rdy || i_frame_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            o_frame_rdy <= 1'b0;
            o_frame_len <= '0;
            o_frame_seq <= '0;
            o_ovf_cnt   <= '0;
        end else if (state == W_CLOSE) begin
            if (rd_free) begin
                rd_bank     <= wr_bank;
                wr_bank     <= ~wr_bank;
                o_frame_rdy <= 1'b1;
                o_frame_len <= close_len;
                o_frame_seq <= o_frame_seq + SEQ_W'(1);
            end else if (o_ovf_cnt != '1) begin
                o_ovf_cnt <= o_ovf_cnt + SEQ_W'(1);
            end
        end else if (i_frame_ack) begin
            o_frame_rdy <= 1'b0;
        end
    end

    eth_frame_dpram #(
        .AW (FRAME_AW + 1),
        .DW (32)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr ({wr_bank, wr_ptr[FRAME_AW-1:0]}),
        .wdata (i_wr_data),
        .raddr ({rd_bank, i_rd_addr}),
        .rdata (o_rd_data)
    );

endmodule
